sr_cmd_gen: RTL and testbench

Control-generation stage that sits directly upstream of the `sr_ff` flip-flop and drives its `s`/`r` inputs. Two raw, asynchronous, bouncy pushbutton inputs are synchronised and debounced. Each debounced rising edge becomes a clean, fixed-width set or reset pulse. The block guarantees the flip-flop never sees `s=r=1`: simultaneous or overlapping requests are rejected and flagged, and a guard gap separates consecutive commands.

---
 rtl/sr_cmd_pkg.sv | 16 +
 rtl/sync_debounce.sv | 53 +++++
 rtl/sr_cmd_gen.sv | 114 +++++++++++
 tb/tb_sr_cmd_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sr_cmd_pkg.sv
// Shared definitions for the set/reset command generator: one-hot FSM
// state encoding and the sizing rule for the pulse/gap counter.
package sr_cmd_pkg;

  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_SET  = 4'b0010;
  localparam logic [3:0] ST_RST  = 4'b0100;
  localparam logic [3:0] ST_GAP  = 4'b1000;

  function automatic int cnt_width(input int pulse, input int gap);
    int m;
    m = (pulse > gap) ? pulse : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// One pushbutton channel: 2-flop synchroniser, stability-count debouncer
// and rising-edge detector on the debounced level.
module sync_debounce
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronised level disagrees; it clears on
  // agreement and also on the flip itself.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST) level_d = sync2_q;
      else               cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~prev_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns two debounced pushbuttons into clean, mutually exclusive s/r pulses
// for an SR flip-flop, with a forced idle gap and conflict/drop flags.
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 1,
  parameter int GAP_CYCLES      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_set,
  input  logic btn_reset,
  output logic s,
  output logic r,
  output logic conflict,
  output logic dropped
);

  localparam int CNT_W = cnt_width(PULSE_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic             level_set, rise_set, level_rst, rise_rst;
  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s_q, s_d, r_q, r_d;
  logic             conflict_q, conflict_d, dropped_q, dropped_d;
  logic             busy;

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_set),
    .level (level_set),
    .rise  (rise_set)
  );

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_reset),
    .level (level_rst),
    .rise  (rise_rst)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
      dropped_q  <= dropped_d;
    end
  end

  // A rise on one channel is only accepted while the other channel's
  // debounced level is low; that also rejects simultaneous edges.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (rise_set && !level_rst) begin
          state_d = ST_SET;
          cnt_d   = PULSE_LD;
        end else if (rise_rst && !level_set) begin
          state_d = ST_RST;
          cnt_d   = PULSE_LD;
        end
      end
      ST_SET, ST_RST: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (GAP_CYCLES > 0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (cnt_q != '0) cnt_d   = cnt_q - 1'b1;
        else             state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    s_d        = (state_d == ST_SET);
    r_d        = (state_d == ST_RST);
    conflict_d = !busy && ((rise_set && level_rst) || (rise_rst && level_set));
    dropped_d  = busy && (rise_set || rise_rst);
  end

  assign s        = s_q;
  assign r        = r_q;
  assign conflict = conflict_q;
  assign dropped  = dropped_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Scoreboard bench for sr_cmd_gen: expected output pulses (kind, start edge,
// width) are queued as buttons are driven and matched as pulses appear.
module tb_sr_cmd_gen;

  localparam int D = 4;
  localparam int K_S = 0, K_R = 1, K_C = 2, K_D = 3;

  typedef struct {
    int kind;
    int at;
    int width;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bs0 = 1'b0, br0 = 1'b0, bs1 = 1'b0, br1 = 1'b0;
  logic s0, r0, c0, d0, s1, r1, c1, d1;

  int   cyc   = 0;
  int   n_chk = 0;
  int   n_err = 0;
  ev_t  q0[$];
  ev_t  q1[$];
  logic [3:0] prv [2];
  int   st [2][4];
  int   ew [2][4];

  sr_cmd_gen #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(1), .GAP_CYCLES(2)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .btn_set   (bs0),
    .btn_reset (br0),
    .s         (s0),
    .r         (r0),
    .conflict  (c0),
    .dropped   (d0)
  );

  sr_cmd_gen #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(3), .GAP_CYCLES(2)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .btn_set   (bs1),
    .btn_reset (br1),
    .s         (s1),
    .r         (r1),
    .conflict  (c1),
    .dropped   (d1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int expv);
    n_chk++;
    if (obs != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic string nm(input int j);
    case (j)
      0:       return "s";
      1:       return "r";
      2:       return "conflict";
      default: return "dropped";
    endcase
  endfunction

  task automatic push(input int i, input int kind, input int at, input int width);
    ev_t e;
    e.kind  = kind;
    e.at    = at;
    e.width = width;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic mon(input int i, input logic [3:0] v);
    ev_t  e;
    logic got;
    for (int j = 0; j < 4; j++) begin
      if (v[j] && !prv[i][j]) begin
        got = 1'b0;
        if (i == 0 && q0.size() > 0) begin
          e = q0.pop_front(); got = 1'b1;
        end else if (i == 1 && q1.size() > 0) begin
          e = q1.pop_front(); got = 1'b1;
        end
        st[i][j] = cyc;
        if (!got) begin
          check($sformatf("dut%0d_unexpected_%s", i, nm(j)), 1, 0);
          ew[i][j] = -1;
        end else begin
          check($sformatf("dut%0d_kind_%s", i, nm(j)), j, e.kind);
          check($sformatf("dut%0d_start_%s", i, nm(j)), cyc, e.at);
          ew[i][j] = e.width;
        end
      end else if (!v[j] && prv[i][j] && ew[i][j] >= 0) begin
        check($sformatf("dut%0d_width_%s", i, nm(j)), cyc - st[i][j], ew[i][j]);
      end
      prv[i][j] = v[j];
    end
    check($sformatf("dut%0d_s_and_r", i), int'(v[0] & v[1]), 0);
    check($sformatf("dut%0d_conflict_and_dropped", i), int'(v[2] & v[3]), 0);
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, {d0, c0, r0, s0});
    mon(1, {d1, c1, r1, s1});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic flush(input string tag);
    check({tag, "_pending_dut0"}, q0.size(), 0);
    check({tag, "_pending_dut1"}, q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  task automatic idle_outputs(input string tag);
    check({tag, "_s0"}, int'(s0), 0);
    check({tag, "_r0"}, int'(r0), 0);
    check({tag, "_conflict0"}, int'(c0), 0);
    check({tag, "_dropped0"}, int'(d0), 0);
    check({tag, "_s1"}, int'(s1), 0);
    check({tag, "_r1"}, int'(r1), 0);
  endtask

  initial begin
    int k;
    prv[0] = '0;
    prv[1] = '0;

    // Reset held with buttons toggling: nothing may come out.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bs0 = ~bs0; br0 = ~br0; bs1 = ~bs1; br1 = ~br1;
      #1 idle_outputs("in_reset");
    end
    @(negedge clk);
    bs0 = 1'b0; br0 = 1'b0; bs1 = 1'b0; br1 = 1'b0;
    rst = 1'b1;
    tick(12);
    idle_outputs("after_release");
    flush("reset");

    // Clean set, then a reset edge landing in the last gap cycle.
    k = cyc;
    bs0 = 1'b1;
    push(0, K_S, k + 3 + D, 1);
    tick(3);
    br0 = 1'b1;
    push(0, K_D, k + 6 + D, 1);
    tick(12);
    bs0 = 1'b0; br0 = 1'b0;
    tick(20);
    flush("clean_set");

    // Short bounce, then a long hold.
    br0 = 1'b1;
    tick(3);
    br0 = 1'b0;
    tick(15);
    k = cyc;
    br0 = 1'b1;
    push(0, K_R, k + 3 + D, 1);
    tick(10);
    br0 = 1'b0;
    tick(20);
    flush("bounce");

    // Both buttons together.
    k = cyc;
    bs0 = 1'b1; br0 = 1'b1;
    push(0, K_C, k + 3 + D, 1);
    tick(12);
    bs0 = 1'b0; br0 = 1'b0;
    tick(20);
    flush("conflict_same");

    // Reset request while the set level is still held, FSM idle.
    k = cyc;
    bs0 = 1'b1;
    push(0, K_S, k + 3 + D, 1);
    tick(8);
    br0 = 1'b1;
    push(0, K_C, k + 11 + D, 1);
    tick(12);
    bs0 = 1'b0; br0 = 1'b0;
    tick(20);
    flush("conflict_level");

    // Wide pulse: reset edge debounces while s is high.
    k = cyc;
    bs1 = 1'b1;
    push(1, K_S, k + 3 + D, 3);
    tick(1);
    br1 = 1'b1;
    push(1, K_D, k + 4 + D, 1);
    tick(15);
    bs1 = 1'b0; br1 = 1'b0;
    tick(20);
    flush("busy_drop");

    // Reset mid-pulse, released with the button still held.
    k = cyc;
    bs1 = 1'b1;
    push(1, K_S, k + 3 + D, 1);
    tick(3 + D);
    check("s1_high_before_reset", int'(s1), 1);
    rst = 1'b0;
    #1 check("s1_async_drop", int'(s1), 0);
    @(negedge clk);
    rst = 1'b1;
    k = cyc;
    push(1, K_S, k + 3 + D, 3);
    tick(15);
    bs1 = 1'b0;
    tick(20);
    flush("reset_mid_pulse");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
